// File: rtl/mem_stage.sv
// RV32I memory stage: issues data-memory loads/stores over req/ack, formats load data,
// stalls the front end while the memory is busy, and owns the MEM/WB register.
//
// state  | meaning
// IDLE   | no access outstanding; request (if any) issued combinationally from EX/MEM
// WAIT   | request issued, waiting for DMEM_ACK; front end frozen
module mem_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        VALID_EM,
    input  logic        MemRead_EM,
    input  logic        MemWrite_EM,
    input  logic [2:0]  Funct3_EM,
    input  logic [31:0] ALU_VAL_EM,
    input  logic [31:0] RS2_VAL_EM,
    input  logic [1:0]  MemtoReg_EM,
    input  logic        RegWrite_EM,
    input  logic [4:0]  RD_EM,
    input  logic [31:0] PC4_EM,
    output logic        DMEM_REQ,
    output logic        DMEM_WE,
    output logic [31:0] DMEM_ADDR,
    output logic [3:0]  DMEM_WSTRB,
    output logic [31:0] DMEM_WDATA,
    input  logic        DMEM_ACK,
    input  logic [31:0] DMEM_RDATA,
    output logic        STALL_MEM,
    output logic        VALID_MW,
    output logic        RegWrite_MW,
    output logic        MISALIGN_MW,
    output logic [4:0]  RD_MW,
    output logic [1:0]  MemtoReg_MW,
    output logic [31:0] MEM_DATA_MW,
    output logic [31:0] PC4_MW,
    output logic [31:0] ALU_VAL_MW
);
    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      state_q, state_d;
    logic        valid_mw_q, valid_mw_d;
    logic        regwrite_mw_q, regwrite_mw_d;
    logic        misalign_mw_q, misalign_mw_d;
    logic [4:0]  rd_mw_q, rd_mw_d;
    logic [1:0]  memtoreg_mw_q, memtoreg_mw_d;
    logic [31:0] mem_data_mw_q, mem_data_mw_d;
    logic [31:0] pc4_mw_q, pc4_mw_d;
    logic [31:0] alu_val_mw_q, alu_val_mw_d;

    logic        mem_op, f3_ok, misaligned, illegal, req, stall, load_done;
    logic [1:0]  byte_off;
    logic [31:0] rdata_shifted, load_data;
    logic [15:0] half_sel;

    always_comb begin
        byte_off   = ALU_VAL_EM[1:0];
        mem_op     = VALID_EM & (MemRead_EM | MemWrite_EM);
        if (MemRead_EM)
            f3_ok = (Funct3_EM != 3'b011) && (Funct3_EM != 3'b110) && (Funct3_EM != 3'b111);
        else
            f3_ok = (Funct3_EM == 3'b000) || (Funct3_EM == 3'b001) || (Funct3_EM == 3'b010);
        misaligned = ((Funct3_EM[1:0] == 2'b01) & byte_off[0]) |
                     ((Funct3_EM[1:0] == 2'b10) & (|byte_off));
        illegal    = mem_op & (~f3_ok | misaligned);
        // Reset gates the request directly so it drops even mid-WAIT.
        req        = rst_n & ((state_q == S_WAIT) | (mem_op & ~illegal));
        stall      = req & ~DMEM_ACK;
        load_done  = req & DMEM_ACK & MemRead_EM;
    end

    always_comb begin
        DMEM_REQ   = req;
        STALL_MEM  = stall;
        DMEM_WE    = MemWrite_EM;
        DMEM_ADDR  = {ALU_VAL_EM[31:2], 2'b00};
        DMEM_WSTRB = 4'b0000;
        DMEM_WDATA = RS2_VAL_EM;
        case (Funct3_EM[1:0])
            2'b00: begin
                DMEM_WDATA = {4{RS2_VAL_EM[7:0]}};
                if (MemWrite_EM) DMEM_WSTRB = 4'b0001 << byte_off;
            end
            2'b01: begin
                DMEM_WDATA = {2{RS2_VAL_EM[15:0]}};
                if (MemWrite_EM) DMEM_WSTRB = 4'b0011 << byte_off;
            end
            default: begin
                if (MemWrite_EM) DMEM_WSTRB = 4'b1111;
            end
        endcase
    end

    always_comb begin
        rdata_shifted = DMEM_RDATA >> {byte_off, 3'b000};
        half_sel      = byte_off[1] ? DMEM_RDATA[31:16] : DMEM_RDATA[15:0];
        case (Funct3_EM)
            3'b000:  load_data = {{24{rdata_shifted[7]}}, rdata_shifted[7:0]};
            3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
            3'b100:  load_data = {24'h0, rdata_shifted[7:0]};
            3'b101:  load_data = {16'h0, half_sel};
            default: load_data = DMEM_RDATA;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req && !DMEM_ACK) state_d = S_WAIT;
            S_WAIT:  if (DMEM_ACK) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        valid_mw_d    = valid_mw_q;
        regwrite_mw_d = regwrite_mw_q;
        misalign_mw_d = misalign_mw_q;
        rd_mw_d       = rd_mw_q;
        memtoreg_mw_d = memtoreg_mw_q;
        mem_data_mw_d = mem_data_mw_q;
        pc4_mw_d      = pc4_mw_q;
        alu_val_mw_d  = alu_val_mw_q;
        if (stall) begin
            valid_mw_d    = 1'b0;
            regwrite_mw_d = 1'b0;
            misalign_mw_d = 1'b0;
        end else begin
            valid_mw_d    = VALID_EM;
            regwrite_mw_d = RegWrite_EM & ~illegal;
            misalign_mw_d = illegal;
            rd_mw_d       = RD_EM;
            memtoreg_mw_d = MemtoReg_EM;
            mem_data_mw_d = load_done ? load_data : 32'h0;
            pc4_mw_d      = PC4_EM;
            alu_val_mw_d  = ALU_VAL_EM;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            valid_mw_q    <= 1'b0;
            regwrite_mw_q <= 1'b0;
            misalign_mw_q <= 1'b0;
            rd_mw_q       <= 5'h0;
            memtoreg_mw_q <= 2'h0;
            mem_data_mw_q <= 32'h0;
            pc4_mw_q      <= 32'h0;
            alu_val_mw_q  <= 32'h0;
        end else begin
            state_q       <= state_d;
            valid_mw_q    <= valid_mw_d;
            regwrite_mw_q <= regwrite_mw_d;
            misalign_mw_q <= misalign_mw_d;
            rd_mw_q       <= rd_mw_d;
            memtoreg_mw_q <= memtoreg_mw_d;
            mem_data_mw_q <= mem_data_mw_d;
            pc4_mw_q      <= pc4_mw_d;
            alu_val_mw_q  <= alu_val_mw_d;
        end
    end

    assign VALID_MW    = valid_mw_q;
    assign RegWrite_MW = regwrite_mw_q;
    assign MISALIGN_MW = misalign_mw_q;
    assign RD_MW       = rd_mw_q;
    assign MemtoReg_MW = memtoreg_mw_q;
    assign MEM_DATA_MW = mem_data_mw_q;
    assign PC4_MW      = pc4_mw_q;
    assign ALU_VAL_MW  = alu_val_mw_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: driver issues directed ops and queues the expected
// MEM/WB contents; a monitor pops and compares whenever VALID_MW is presented.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        VALID_EM, MemRead_EM, MemWrite_EM;
    logic [2:0]  Funct3_EM;
    logic [31:0] ALU_VAL_EM, RS2_VAL_EM, PC4_EM;
    logic [1:0]  MemtoReg_EM;
    logic        RegWrite_EM;
    logic [4:0]  RD_EM;
    logic        DMEM_REQ, DMEM_WE, DMEM_ACK;
    logic [31:0] DMEM_ADDR, DMEM_WDATA, DMEM_RDATA;
    logic [3:0]  DMEM_WSTRB;
    logic        STALL_MEM, VALID_MW, RegWrite_MW, MISALIGN_MW;
    logic [4:0]  RD_MW;
    logic [1:0]  MemtoReg_MW;
    logic [31:0] MEM_DATA_MW, PC4_MW, ALU_VAL_MW;

    int total = 0;
    int bad   = 0;
    int tag   = 0;
    logic [105:0] exp_q[$];

    mem_stage dut (
        .clk(clk), .rst_n(rst_n),
        .VALID_EM(VALID_EM), .MemRead_EM(MemRead_EM), .MemWrite_EM(MemWrite_EM),
        .Funct3_EM(Funct3_EM), .ALU_VAL_EM(ALU_VAL_EM), .RS2_VAL_EM(RS2_VAL_EM),
        .MemtoReg_EM(MemtoReg_EM), .RegWrite_EM(RegWrite_EM), .RD_EM(RD_EM), .PC4_EM(PC4_EM),
        .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
        .DMEM_WSTRB(DMEM_WSTRB), .DMEM_WDATA(DMEM_WDATA),
        .DMEM_ACK(DMEM_ACK), .DMEM_RDATA(DMEM_RDATA), .STALL_MEM(STALL_MEM),
        .VALID_MW(VALID_MW), .RegWrite_MW(RegWrite_MW), .MISALIGN_MW(MISALIGN_MW),
        .RD_MW(RD_MW), .MemtoReg_MW(MemtoReg_MW), .MEM_DATA_MW(MEM_DATA_MW),
        .PC4_MW(PC4_MW), .ALU_VAL_MW(ALU_VAL_MW)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [105:0] mw_now();
        return {VALID_MW, RegWrite_MW, MISALIGN_MW, RD_MW, MemtoReg_MW,
                MEM_DATA_MW, PC4_MW, ALU_VAL_MW};
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && VALID_MW === 1'b1) begin
            logic [105:0] e;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL mw_unexpected: got %h expected no valid output", mw_now());
            end else begin
                e = exp_q.pop_front();
                if (mw_now() !== e) begin
                    bad++;
                    $display("FAIL mw_entry: got %h expected %h at %0t", mw_now(), e, $time);
                end
            end
        end
    end

    task automatic idle();
        VALID_EM = 1'b0; MemRead_EM = 1'b0; MemWrite_EM = 1'b0; DMEM_ACK = 1'b0;
        @(posedge clk); #1;
    endtask

    // k: cycles from first REQ to ACK; for ops expecting no REQ, k==0 drives a stray ACK.
    task automatic op(input string nm, input logic rd_, input logic wr_, input logic [2:0] f3,
                      input logic [31:0] addr, input logic [31:0] rs2, input logic [31:0] rdata,
                      input int k, input logic exp_req, input logic [31:0] exp_data,
                      input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        int n;
        logic mis;
        tag++;
        VALID_EM = 1'b1; MemRead_EM = rd_; MemWrite_EM = wr_; Funct3_EM = f3;
        ALU_VAL_EM = addr; RS2_VAL_EM = rs2; RegWrite_EM = 1'b1; MemtoReg_EM = 2'b01;
        RD_EM = tag[4:0]; PC4_EM = 32'h400 + 32'(tag) * 4;
        mis = (rd_ | wr_) & ~exp_req;
        n = exp_req ? k : 0;
        for (int c = 0; c <= n; c++) begin
            DMEM_ACK   = (c == k);
            DMEM_RDATA = (c == n) ? rdata : 32'hDEADBEEF;
            #1;
            chk({nm, "_req"}, 32'(DMEM_REQ), 32'(exp_req));
            chk({nm, "_stall"}, 32'(STALL_MEM), 32'(c < n));
            if (exp_req) begin
                chk({nm, "_addr"}, DMEM_ADDR, {addr[31:2], 2'b00});
                chk({nm, "_we"}, 32'(DMEM_WE), 32'(wr_));
                chk({nm, "_strb"}, 32'(DMEM_WSTRB), 32'(exp_strb));
                if (wr_) chk({nm, "_wdata"}, DMEM_WDATA, exp_wdata);
            end
            if (c == n)
                exp_q.push_back({1'b1, ~mis, mis, tag[4:0], 2'b01, exp_data, PC4_EM, addr});
            @(posedge clk); #1;
            if (c < n) chk({nm, "_bubble"}, 32'(VALID_MW), 32'h0);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        VALID_EM = 1'b1; MemRead_EM = 1'b1; MemWrite_EM = 1'b0; Funct3_EM = 3'b010;
        ALU_VAL_EM = 32'h1000; RS2_VAL_EM = 32'h0; MemtoReg_EM = 2'b01; RegWrite_EM = 1'b1;
        RD_EM = 5'd1; PC4_EM = 32'h4; DMEM_ACK = 1'b0; DMEM_RDATA = 32'h0;
        #12;
        chk("rst_req", 32'(DMEM_REQ), 32'h0);
        chk("rst_stall", 32'(STALL_MEM), 32'h0);
        chk("rst_mw_lo", mw_now()[31:0], 32'h0);
        chk("rst_mw_hi", 32'(mw_now()[105:64]), 32'h0);
        VALID_EM = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        op("lw",  1, 0, 3'b010, 32'h1000, 32'h0, 32'h80FF1234, 0, 1, 32'h80FF1234, 4'b0000, 32'h0);
        op("lb",  1, 0, 3'b000, 32'h1003, 32'h0, 32'h80FF1234, 0, 1, 32'hFFFFFF80, 4'b0000, 32'h0);
        op("lbu", 1, 0, 3'b100, 32'h1003, 32'h0, 32'h80FF1234, 0, 1, 32'h00000080, 4'b0000, 32'h0);
        op("lh",  1, 0, 3'b001, 32'h1002, 32'h0, 32'h80FF1234, 0, 1, 32'hFFFF80FF, 4'b0000, 32'h0);
        op("lhu", 1, 0, 3'b101, 32'h1000, 32'h0, 32'h80FF1234, 0, 1, 32'h00001234, 4'b0000, 32'h0);
        op("sb",  0, 1, 3'b000, 32'h2001, 32'h123456AB, 32'h0, 0, 1, 32'h0, 4'b0010, 32'hABABABAB);
        op("sh",  0, 1, 3'b001, 32'h2002, 32'h123456AB, 32'h0, 0, 1, 32'h0, 4'b1100, 32'h56AB56AB);
        op("sw",  0, 1, 3'b010, 32'h2004, 32'h123456AB, 32'h0, 0, 1, 32'h0, 4'b1111, 32'h123456AB);
        idle();
        op("lw_k3", 1, 0, 3'b010, 32'h1000, 32'h0, 32'h80FF1234, 3, 1, 32'h80FF1234, 4'b0000, 32'h0);
        op("lw_mis", 1, 0, 3'b010, 32'h1002, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0000, 32'h0);
        op("sh_mis", 0, 1, 3'b001, 32'h2003, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0000, 32'h0);
        op("ld_bad", 1, 0, 3'b011, 32'h1000, 32'h0, 32'h0, 1, 0, 32'h0, 4'b0000, 32'h0);
        op("alu",   0, 0, 3'b011, 32'hCAFEF00D, 32'h0, 32'h0, 0, 0, 32'h0, 4'b0000, 32'h0);
        op("lb_k1", 1, 0, 3'b000, 32'h1001, 32'h0, 32'h00007F00, 1, 1, 32'h0000007F, 4'b0000, 32'h0);
        op("sb_k2", 0, 1, 3'b000, 32'h3003, 32'h000000C5, 32'h0, 2, 1, 32'h0, 4'b1000, 32'hC5C5C5C5);
        idle();

        // Abandon a load in WAIT via asynchronous reset.
        VALID_EM = 1'b1; MemRead_EM = 1'b1; MemWrite_EM = 1'b0; Funct3_EM = 3'b010;
        ALU_VAL_EM = 32'h1000; DMEM_ACK = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wait_req", 32'(DMEM_REQ), 32'h1);
        chk("wait_stall", 32'(STALL_MEM), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("rstw_req", 32'(DMEM_REQ), 32'h0);
        chk("rstw_stall", 32'(STALL_MEM), 32'h0);
        chk("rstw_mw_lo", mw_now()[31:0], 32'h0);
        chk("rstw_mw_mid", mw_now()[63:32], 32'h0);
        chk("rstw_mw_hi", 32'(mw_now()[105:64]), 32'h0);
        VALID_EM = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        op("lw_post", 1, 0, 3'b010, 32'h1004, 32'h0, 32'h0BADF00D, 0, 1, 32'h0BADF00D, 4'b0000, 32'h0);
        idle();
        idle();
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the 5-stage RV32I pipeline, between the EX/MEM register (`_EM` signals) and the write-back select logic. It issues loads and stores to the data memory over a req/ack handshake. It aligns and sign-extends load data, and generates byte strobes for stores. It stalls the front of the pipeline while the memory is busy. It owns the MEM/WB pipeline register (`_MW` outputs) that feeds write-back.

## Interface
- No parameters.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `VALID_EM` in 1: the EX/MEM slot holds a real instruction.
- `MemRead_EM`, `MemWrite_EM` in 1 each: load or store; never both set.
- `Funct3_EM` in 3: access width and signedness (RV32I load/store funct3).
- `ALU_VAL_EM` in 32: effective address for memory ops; ALU result otherwise.
- `RS2_VAL_EM` in 32: store data.
- `MemtoReg_EM` in 2, `RegWrite_EM` in 1, `RD_EM` in 5, `PC4_EM` in 32: write-back controls, passed through.
- `DMEM_REQ` out 1, `DMEM_WE` out 1, `DMEM_ADDR` out 32 (bits [1:0] = 0), `DMEM_WSTRB` out 4, `DMEM_WDATA` out 32: data memory request.
- `DMEM_ACK` in 1, `DMEM_RDATA` in 32: completion; `DMEM_RDATA` is valid only in the ACK cycle.
- `STALL_MEM` out 1: freezes PC, IF/ID, ID/EX and EX/MEM. All `_EM` inputs stay stable while it is high.
- `VALID_MW`, `RegWrite_MW`, `MISALIGN_MW` out 1 each; `RD_MW` out 5; `MemtoReg_MW` out 2; `MEM_DATA_MW`, `PC4_MW`, `ALU_VAL_MW` out 32: MEM/WB register.

## Operation
- mem_op = `VALID_EM` & (`MemRead_EM` | `MemWrite_EM`).
- Illegal condition (no request is issued):
  - halfword access with addr[0] = 1;
  - word access with addr[1:0] ≠ 0;
  - funct3 ∈ {011, 110, 111} for loads;
  - funct3 ∉ {000, 001, 010} for stores.
- FSM, 2 states:
  - IDLE: `DMEM_REQ` = mem_op & legal, combinational. If `DMEM_ACK` is high in the same cycle, the access completes with no stall. Otherwise go to WAIT.
  - WAIT: `DMEM_REQ` = 1 with the same request fields. On `DMEM_ACK`, complete and return to IDLE.
- `STALL_MEM` = `DMEM_REQ` & ~`DMEM_ACK`.
- Request fields:
  - `DMEM_ADDR` = {addr[31:2], 2'b00}; `DMEM_WE` = `MemWrite_EM`.
  - SB: `DMEM_WSTRB` = 0001 << addr[1:0]; `DMEM_WDATA` = rs2[7:0] replicated ×4.
  - SH: `DMEM_WSTRB` = 0011 << addr[1:0]; `DMEM_WDATA` = rs2[15:0] replicated ×2.
  - SW: `DMEM_WSTRB` = 1111; `DMEM_WDATA` = rs2.
  - Loads: `DMEM_WSTRB` = 0000.
- Load formatting from the ACK-cycle `DMEM_RDATA`, selected by addr[1:0]:
  - LB/LH: sign-extend the selected byte/halfword.
  - LBU/LHU: zero-extend.
  - LW: word as-is.
- MEM/WB register, updated on every edge where `STALL_MEM` = 0:
  - Normal: copies the `_EM` controls, `ALU_VAL_EM` and `PC4_EM`. `VALID_MW` = `VALID_EM`.
  - `MEM_DATA_MW` = formatted load data for completed loads, 0 otherwise.
  - Illegal memory op: `MISALIGN_MW` = 1, `RegWrite_MW` = 0; other fields copied.
  - While `STALL_MEM` = 1, a bubble is written instead: `VALID_MW` = 0, `RegWrite_MW` = 0, `MISALIGN_MW` = 0; other fields don't-care (hold).
- Non-memory valid instructions pass through in one cycle with no request.

## Timing
- Reset (rst_n low, asynchronous):
  - FSM → IDLE.
  - All `_MW` outputs = 0.
  - `DMEM_REQ` = 0 and `STALL_MEM` = 0, forced combinationally while reset is asserted, regardless of `_EM` inputs.
- Latency: an op accepted with ACK in its first REQ cycle reaches `_MW` at the next edge (1 cycle).
- ACK k cycles after the first REQ cycle:
  - `STALL_MEM` is high for k cycles, with k bubbles into MW.
  - The result lands at the edge ending the ACK cycle.
- REQ is held high with stable fields until ACK. ACK without REQ is ignored.
- Back-to-back memory ops: the next op may present REQ in the cycle immediately after an ACK.
- Reset during WAIT: the request is abandoned and REQ drops immediately. The memory must tolerate an abandoned request; a store may or may not have been performed.

## Test plan
- LW at 0x1000, RDATA 0x80FF1234, ACK same cycle:
  - REQ = 1, ADDR = 0x1000, STALL = 0.
  - Next edge: MEM_DATA_MW = 0x80FF1234, VALID_MW = 1.
- Same RDATA, LB at 0x1003 → 0xFFFFFF80; LBU → 0x00000080; LH at 0x1002 → 0xFFFF80FF; LHU at 0x1000 → 0x00001234.
- SB at 0x2001, rs2 0x123456AB → WSTRB 0010, WDATA 0xABABABAB, WE 1; SH at 0x2002 → WSTRB 1100, WDATA 0x56AB56AB.
- LW with ACK delayed 3 cycles:
  - STALL_MEM high for exactly 3 cycles, with fields stable throughout.
  - MW shows 3 bubbles (VALID_MW 0), then load data.
- LW at 0x1002 → no REQ, no stall, next edge MISALIGN_MW = 1, RegWrite_MW = 0. Same response for SH at 0x2003.
- Reset asserted in WAIT → REQ and STALL drop asynchronously, all `_MW` outputs 0. After release, the next LW completes normally.
